// File: rtl/mem_stage_bytelane.sv
// mem_stage_bytelane: MEM stage with byte-lane data memory, misalignment trap and MEM/WB register
module mem_stage_bytelane #(
    parameter int MEM_AW = 10,
    parameter int RA_W   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            write_reg_i,
    input  logic            mem_to_reg_i,
    input  logic            write_mem_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [31:0]     alu_result_i,
    input  logic [31:0]     write_mem_val_i,
    input  logic [RA_W-1:0] des_r_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic            write_reg_o,
    output logic            mem_to_reg_o,
    output logic [31:0]     data_from_mem_o,
    output logic [31:0]     alu_result_o,
    output logic [RA_W-1:0] des_r_o,
    output logic            exc_o,
    output logic [31:0]     exc_addr_o
);
    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] idx;
    logic [1:0]        lane;
    logic              active, misal, st_en, ld_en;
    logic [3:0]        be;
    logic [31:0]       wd, rd, ld_data;
    logic [7:0]        rb;
    logic [15:0]       rh;
    always_comb begin
        idx     = alu_result_i[MEM_AW+1:2];
        lane    = alu_result_i[1:0];
        active  = valid_i & ~stall_i & ~flush_i;
        misal   = (write_mem_i | mem_to_reg_i) & ((size_i == 2'b11) | ((size_i == 2'b01) & lane[0]) |
                  ((size_i == 2'b10) & (lane != 2'b00)));
        st_en   = active & write_mem_i & ~misal;
        ld_en   = active & mem_to_reg_i & ~misal;
        be      = (size_i == 2'b00) ? (4'b0001 << lane) : (size_i == 2'b01) ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd      = (size_i == 2'b00) ? {4{write_mem_val_i[7:0]}} : (size_i == 2'b01) ? {2{write_mem_val_i[15:0]}} : write_mem_val_i;
        rd      = mem[idx];
        rb      = rd[{lane, 3'b000} +: 8];
        rh      = lane[1] ? rd[31:16] : rd[15:0];
        ld_data = (size_i == 2'b00) ? {{24{~unsigned_i & rb[7]}}, rb} :
                  (size_i == 2'b01) ? {{16{~unsigned_i & rh[15]}}, rh} : rd;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (st_en && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o         <= 1'b0;
            write_reg_o     <= 1'b0;
            mem_to_reg_o    <= 1'b0;
            data_from_mem_o <= '0;
            alu_result_o    <= '0;
            des_r_o         <= '0;
            exc_o           <= 1'b0;
            exc_addr_o      <= '0;
        end else if (!stall_i) begin
            valid_o      <= active;
            write_reg_o  <= active & write_reg_i & ~misal;
            mem_to_reg_o <= active & mem_to_reg_i & ~misal;
            exc_o        <= active & misal;
            if (active) begin
                alu_result_o <= alu_result_i;
                des_r_o      <= des_r_i;
                exc_addr_o   <= misal ? alu_result_i : '0;
            end
            if (ld_en) data_from_mem_o <= ld_data;
        end
    end
endmodule

// File: tb/tb_mem_stage_bytelane.sv
// tb_mem_stage_bytelane: directed stimulus with an expectation queue drained by an independent monitor
module tb_mem_stage_bytelane;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid_i = 0, write_reg_i = 0, mem_to_reg_i = 0, write_mem_i = 0, unsigned_i = 0;
    logic        stall_i = 0, flush_i = 0;
    logic [1:0]  size_i = 0;
    logic [31:0] alu_result_i = 0, write_mem_val_i = 0;
    logic [4:0]  des_r_i = 0;
    logic        valid_o, write_reg_o, mem_to_reg_o, exc_o;
    logic [31:0] data_from_mem_o, alu_result_o, exc_addr_o;
    logic [4:0]  des_r_o;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        v, wr, m2r, exc, kd, ka, ke;
        logic [31:0] d, alu, ea;
        logic [4:0]  des;
    } exp_t;
    exp_t q[$];
    exp_t cur, m_e;

    mem_stage_bytelane #(.MEM_AW(4), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .write_reg_i(write_reg_i),
        .mem_to_reg_i(mem_to_reg_i), .write_mem_i(write_mem_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .alu_result_i(alu_result_i), .write_mem_val_i(write_mem_val_i),
        .des_r_i(des_r_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(valid_o),
        .write_reg_o(write_reg_o), .mem_to_reg_o(mem_to_reg_o), .data_from_mem_o(data_from_mem_o),
        .alu_result_o(alu_result_o), .des_r_o(des_r_o), .exc_o(exc_o), .exc_addr_o(exc_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 0);
        chk({tag, "_wr"}, 32'(write_reg_o), 0);
        chk({tag, "_m2r"}, 32'(mem_to_reg_o), 0);
        chk({tag, "_exc"}, 32'(exc_o), 0);
        chk({tag, "_data"}, data_from_mem_o, 0);
        chk({tag, "_alu"}, alu_result_o, 0);
        chk({tag, "_des"}, 32'(des_r_o), 0);
        chk({tag, "_eaddr"}, exc_addr_o, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("valid_o", 32'(valid_o), 32'(m_e.v));
            chk("write_reg_o", 32'(write_reg_o), 32'(m_e.wr));
            chk("mem_to_reg_o", 32'(mem_to_reg_o), 32'(m_e.m2r));
            chk("exc_o", 32'(exc_o), 32'(m_e.exc));
            if (m_e.kd) chk("data_from_mem_o", data_from_mem_o, m_e.d);
            if (m_e.ka) begin
                chk("alu_result_o", alu_result_o, m_e.alu);
                chk("des_r_o", 32'(des_r_o), 32'(m_e.des));
            end
            if (m_e.ke) chk("exc_addr_o", exc_addr_o, m_e.ea);
        end
    end

    task automatic drive(input logic v, wm, m2r, wr, input logic [1:0] sz, input logic us,
                         input logic [31:0] a, val, input logic [4:0] ds, input logic st, fl);
        @(negedge clk);
        valid_i = v; write_mem_i = wm; mem_to_reg_i = m2r; write_reg_i = wr; size_i = sz;
        unsigned_i = us; alu_result_i = a; write_mem_val_i = val; des_r_i = ds;
        stall_i = st; flush_i = fl;
    endtask

    task automatic op(input logic wm, m2r, wr, input logic [1:0] sz, input logic us,
                      input logic [31:0] a, val, input logic [4:0] ds, input logic x, input logic [31:0] d);
        drive(1'b1, wm, m2r, wr, sz, us, a, val, ds, 1'b0, 1'b0);
        cur.v = 1'b1; cur.exc = x; cur.wr = wr & ~x; cur.m2r = m2r & ~x;
        cur.ka = ~x; cur.alu = a; cur.des = ds; cur.ke = x; cur.ea = a;
        if (m2r && !x) begin
            cur.kd = 1'b1;
            cur.d = d;
        end
        q.push_back(cur);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, val, input logic x);
        op(1'b1, 1'b0, 1'b0, sz, 1'b0, a, val, 5'd0, x, 32'd0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic us, input logic [31:0] a,
                      input logic [4:0] ds, input logic x, input logic [31:0] d);
        op(1'b0, 1'b1, 1'b1, sz, us, a, 32'hFFFF_FFFF, ds, x, d);
    endtask

    task automatic stall(input logic fl, input logic [31:0] val);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, val, 5'd9, 1'b1, fl);
        q.push_back(cur);
    endtask

    task automatic bubble(input logic v, fl);
        drive(v, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'h99, 5'd9, 1'b0, fl);
        cur.v = 0; cur.wr = 0; cur.m2r = 0; cur.exc = 0; cur.kd = 0; cur.ka = 0; cur.ke = 0;
        q.push_back(cur);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cur = '{v: 0, wr: 0, m2r: 0, exc: 0, kd: 1, ka: 1, ke: 1, d: 0, alu: 0, ea: 0, des: 0};
        #12;
        rst_chk("reset");
        @(negedge clk) rst_n = 1'b1;
        st(2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
        ld(2'b10, 1'b0, 32'h10, 5'd5, 1'b0, 32'hDEAD_BEEF);
        st(2'b00, 32'h11, 32'h0000_007F, 1'b0);
        ld(2'b10, 1'b1, 32'h10, 5'd6, 1'b0, 32'hDEAD_7FEF);
        ld(2'b00, 1'b0, 32'h13, 5'd7, 1'b0, 32'hFFFF_FFDE);
        ld(2'b00, 1'b1, 32'h13, 5'd8, 1'b0, 32'h0000_00DE);
        st(2'b10, 32'h20, 32'h1122_3344, 1'b0);
        st(2'b01, 32'h22, 32'h0000_8001, 1'b0);
        ld(2'b01, 1'b0, 32'h22, 5'd10, 1'b0, 32'hFFFF_8001);
        ld(2'b01, 1'b1, 32'h22, 5'd11, 1'b0, 32'h0000_8001);
        ld(2'b10, 1'b0, 32'h12, 5'd12, 1'b1, 32'h0);
        st(2'b01, 32'h23, 32'h0000_AAAA, 1'b1);
        ld(2'b10, 1'b0, 32'h20, 5'd13, 1'b0, 32'h8001_3344);
        ld(2'b11, 1'b0, 32'h10, 5'd14, 1'b1, 32'h0);
        st(2'b10, 32'h30, 32'h1234_5678, 1'b0);
        ld(2'b10, 1'b0, 32'h30, 5'd15, 1'b0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) stall(1'b0, 32'h55);
        bubble(1'b1, 1'b1);
        ld(2'b10, 1'b0, 32'h30, 5'd16, 1'b0, 32'h1234_5678);
        stall(1'b1, 32'h77);
        bubble(1'b0, 1'b0);
        ld(2'b10, 1'b0, 32'h30, 5'd17, 1'b0, 32'h1234_5678);
        ld(2'b10, 1'b0, 32'h12, 5'd18, 1'b1, 32'h0);
        stall(1'b0, 32'h66);
        st(2'b10, 32'h40, 32'hCAFE_F00D, 1'b0);
        ld(2'b10, 1'b0, 32'h00, 5'd19, 1'b0, 32'hCAFE_F00D);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 rst_chk("async_reset");
        chk("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_bytelane.md
Name: mem_stage_bytelane

Overview:
- Parametrised MEM pipeline stage: data memory plus the MEM/WB register.
- Adds byte/halfword/word loads and stores, sign or zero extension, misalignment trapping, and stall/flush control.
- Sits between the EX/MEM register and writeback; outputs feed the WB mux and the forwarding unit.

Parameters:
- MEM_AW, 10, word-address width; memory depth = 2**MEM_AW words of 32 bits.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  instruction present in MEM stage.
- write_reg_i  in  1  instruction writes the register file.
- mem_to_reg_i  in  1  instruction is a load.
- write_mem_i  in  1  instruction is a store.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- unsigned_i  in  1  load zero-extends (1) or sign-extends (0).
- alu_result_i  in  32  byte address for memory ops; pass-through result otherwise.
- write_mem_val_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- des_r_i  in  RA_W  destination register.
- stall_i  in  1  hold the stage.
- flush_i  in  1  squash the current instruction.
- valid_o  out  1  registered valid.
- write_reg_o  out  1  registered register write enable, forced 0 on exception or bubble.
- mem_to_reg_o  out  1  registered load flag.
- data_from_mem_o  out  32  extended load data.
- alu_result_o  out  32  registered alu_result_i.
- des_r_o  out  RA_W  registered destination.
- exc_o  out  1  misaligned or illegal-size access; one-cycle pulse per faulting instruction.
- exc_addr_o  out  32  faulting address, valid when exc_o=1.

Behaviour:
- Reset (rst_n=0, async): all outputs 0. Memory contents are not reset and are undefined after power-up.
- Word index = alu_result_i[MEM_AW+1:2]. Bits above MEM_AW+1 are ignored, so addresses wrap modulo the depth. Byte lane = alu_result_i[1:0].
- active = valid_i & ~stall_i & ~flush_i.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; any access with size_i=11. This check applies only when write_mem_i or mem_to_reg_i is 1.
- Store (active & write_mem_i & aligned): on the clock edge, only the addressed lanes are written.
  - byte: lane addr[1:0] ← val[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} ← val[15:0], little-endian.
  - word: all lanes ← val.
  - Other bytes of the word are unchanged.
- Load (active & mem_to_reg_i & aligned): memory is read combinationally and the result registered on the same edge, giving 1-cycle latency.
  - Select the byte or half by lane, then sign- or zero-extend per unsigned_i. Word loads ignore unsigned_i.
  - A load in the cycle after a store to the same word returns the updated data.
  - When not a load, data_from_mem_o holds its previous value.
- Fault (active & misaligned access): no memory write. Registered outputs: exc_o=1, exc_addr_o=alu_result_i, write_reg_o=0, mem_to_reg_o=0, valid_o=1.
- Non-faulting active edge: exc_o=0 and all control, result and destination fields are registered from the inputs.
- stall_i=1 (dominates valid_i): every output register holds its value, including exc_o, so a pending exc_o stays high. No memory write occurs.
- flush_i=1 and stall_i=0: bubble inserted. valid_o, write_reg_o, mem_to_reg_o and exc_o are 0; no memory write; data and address fields are don't-care.
- stall_i and flush_i both 1: stall wins.
- valid_i=0 and not stalled: same as flush.
- Reset asserted mid-store: the write may or may not complete. Outputs go to 0 immediately.

Test Plan:
- Reset then word store: store 0xDEADBEEF to addr 0x10; next cycle load word addr 0x10 → data_from_mem_o=0xDEADBEEF, write_reg_o=1, exc_o=0.
- Byte store: store byte 0x7F to 0x11, then unsigned load word 0x10 → 0xDEAD7FEF. Then load byte signed at 0x13 → 0xFFFFFFDE; unsigned → 0x000000DE.
- Halfword: store half 0x8001 at 0x22, then load half signed at 0x22 → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned: load word at 0x12 → exc_o=1, exc_addr_o=0x12, write_reg_o=0. Store half at 0x23 → exc_o=1 and a word read of 0x20 is unchanged. size_i=11 → exc_o=1.
- Stall/flush:
  - Hold stall_i=1 for 3 cycles while presenting a store of 0x55 to 0x30 → outputs frozen; later load of 0x30 returns the old value.
  - flush_i=1 with a store → valid_o=0, no write.
  - stall_i and flush_i both 1 → outputs held.
- Wrap and async reset: with MEM_AW=4, store to 0x40 then load 0x00 → same data. Drop rst_n mid-cycle → all outputs 0 before the next edge.
